// File: rtl/anim_sequencer.sv
// -----------------------------------------------------------------------------
// anim_sequencer
//
// Frame sequencer for sprite/animation playback. A period counter advances the
// frame index every PERIOD cycles according to the playback mode latched on
// start (loop, ping-pong, one-shot, still). Each pixel request (x, y) is turned
// into a registered linear address {frame, y, x} into a multi-frame image ROM.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   start       one-cycle pulse: restart from frame 0 and latch mode
//   pause       level: freezes period counter and frame index while in RUN
//   mode        playback mode (0 LOOP, 1 PINGPONG, 2 ONESHOT, 3 STILL)
//   ram_addr_x  pixel column request
//   ram_addr_y  pixel row request
//   rom_addr    registered ROM address {frame, y, x}
//   frame       current frame index
//   busy        high while in RUN
//   frame_tick  one-cycle pulse on every frame change
//   done        one-cycle pulse on sequence completion/wrap
// -----------------------------------------------------------------------------
module anim_sequencer #(
    parameter int FRAMES    = 16,
    parameter int PERIOD    = 33554432,
    parameter int AW        = 8,
    parameter int AUTOSTART = 1,
    localparam int FW       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic [1:0]         mode,
    input  logic [AW-1:0]      ram_addr_x,
    input  logic [AW-1:0]      ram_addr_y,
    output logic [FW+2*AW-1:0] rom_addr,
    output logic [FW-1:0]      frame,
    output logic               busy,
    output logic               frame_tick,
    output logic               done
);

    localparam int CW = $clog2(PERIOD);

    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
    // Frame reached when ping-pong reverses at the top; unused when FRAMES == 1.
    localparam logic [FW-1:0] FRAME_TURN = FW'((FRAMES > 1) ? FRAMES - 2 : 0);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        M_LOOP     = 2'd0,
        M_PINGPONG = 2'd1,
        M_ONESHOT  = 2'd2,
        M_STILL    = 2'd3
    } mode_t;

    state_t               state_q, state_d;
    mode_t                mode_q,  mode_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic [FW-1:0]        frame_q, frame_d;
    logic                 dir_q,   dir_d;
    logic                 tick_q,  tick_d;
    logic                 done_q,  done_d;
    logic [FW+2*AW-1:0]   rom_addr_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        if (start) begin
            // start wins over pause and over a same-cycle period expiry.
            state_d = S_RUN;
            mode_d  = mode_t'(mode);
            cnt_d   = '0;
            frame_d = '0;
            dir_d   = 1'b1;
        end else if (state_q == S_RUN && !pause) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
                unique case (mode_q)
                    M_LOOP: begin
                        if (frame_q == FRAME_LAST) begin
                            frame_d = '0;
                            done_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end
                    M_PINGPONG: begin
                        if (FRAMES > 1) begin
                            if (dir_q) begin
                                if (frame_q == FRAME_LAST) begin
                                    frame_d = FRAME_TURN;
                                    dir_d   = 1'b0;
                                end else begin
                                    frame_d = frame_q + 1'b1;
                                end
                            end else begin
                                if (frame_q == '0) begin
                                    frame_d = FW'(1);
                                    dir_d   = 1'b1;
                                end else begin
                                    frame_d = frame_q - 1'b1;
                                end
                            end
                        end
                        // Landing on frame 0 closes one ping-pong cycle; with a
                        // single frame this degenerates to a done every period.
                        done_d = (frame_d == '0);
                    end
                    M_ONESHOT: begin
                        if (frame_q == FRAME_LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end
                    M_STILL: begin
                        frame_d = '0;
                    end
                endcase
            end
        end

        // Any change of frame value ticks, except the reset-to-0 caused by start.
        tick_d = !start && (frame_d != frame_q);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (AUTOSTART != 0) ? S_RUN : S_IDLE;
            mode_q     <= M_LOOP;
            cnt_q      <= '0;
            frame_q    <= '0;
            dir_q      <= 1'b1;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; rom_addr below relies on seeing the old frame.
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            rom_addr_q <= {frame_q, ram_addr_y, ram_addr_x};
        end
    end

    assign rom_addr   = rom_addr_q;
    assign frame      = frame_q;
    assign busy       = (state_q == S_RUN);
    assign frame_tick = tick_q;
    assign done       = done_q;

endmodule
